// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and widths for the alu_mac_array datapath.
package alu_pkg;

    localparam int unsigned ALU_KIND_XNOR  = 0;
    localparam int unsigned ALU_KIND_MUL   = 1;
    localparam int unsigned BEAT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        StAcc,
        StWait,
        StHold
    } state_e;

endpackage

// File: rtl/alu_mac_array_if.sv
// Beat-in / result-out handshake bundle of alu_mac_array.
// master = producer/consumer side, slave = the datapath.
interface alu_mac_array_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_NUM   = 4,
    parameter int unsigned ACC_WIDTH  = 32
);
    import alu_pkg::*;

    logic                           in_valid_i;
    logic                           in_ready_o;
    logic                           in_last_i;
    logic [LANE_NUM*DATA_WIDTH-1:0] a_i;
    logic [LANE_NUM*DATA_WIDTH-1:0] b_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [ACC_WIDTH-1:0]           acc_o;
    logic [BEAT_CNT_WIDTH-1:0]      beats_o;

    modport master (
        output in_valid_i, in_last_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, acc_o, beats_o
    );

    modport slave (
        input  in_valid_i, in_last_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, acc_o, beats_o
    );

endinterface

// File: rtl/alu_lane.sv
// One combinational lane: XNOR-popcount, signed multiply, or constant zero,
// selected at elaboration time by ALU_KIND.
module alu_lane
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ALU_KIND   = ALU_KIND_XNOR
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  res
);

    if (ALU_KIND == ALU_KIND_XNOR) begin : g_xnor
        logic [DATA_WIDTH-1:0] match;
        assign match = ~(a ^ b);

        always_comb begin
            res = '0;
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                res = res + ACC_WIDTH'(match[i]);
            end
        end
    end else if (ALU_KIND == ALU_KIND_MUL) begin : g_mul
        logic signed [2*DATA_WIDTH-1:0] prod;
        assign prod = (2*DATA_WIDTH)'($signed(a)) * (2*DATA_WIDTH)'($signed(b));
        // prod is signed, so the size cast sign-extends
        assign res  = ACC_WIDTH'(prod);
    end else begin : g_zero
        logic unused_operands;
        assign unused_operands = ^{a, b};
        assign res = '0;
    end

endmodule

// File: rtl/alu_mac_array.sv
// Multi-lane MAC datapath: per-lane op, lane reduction, per-vector accumulation.
// Define ALU_ACC_SAT_EN to make every accumulator add saturate instead of wrap.
module alu_mac_array
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_NUM   = 4,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ALU_KIND   = ALU_KIND_XNOR
) (
    input logic            clk_i,
    input logic            rst_i,
    alu_mac_array_if.slave bus
);

    state_e state_q, state_d;
    logic   in_ready, out_valid, accept;

    logic [ACC_WIDTH-1:0]      lane_res  [LANE_NUM];
    logic [ACC_WIDTH-1:0]      s1_lane_q [LANE_NUM];
    logic                      s1_valid_q, s1_last_q;
    logic [ACC_WIDTH-1:0]      acc_q, res_q, sum;
    logic [BEAT_CNT_WIDTH-1:0] cnt_q, beats_q;

    assign accept          = bus.in_valid_i && in_ready;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.acc_o       = res_q;
    assign bus.beats_o     = beats_q;

    for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
        alu_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .ALU_KIND  (ALU_KIND)
        ) u_lane (
            .a  (bus.a_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .b  (bus.b_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .res(lane_res[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_last_q  <= accept && bus.in_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_lane_q <= lane_res;
        end
    end

`ifdef ALU_ACC_SAT_EN
    // Wide enough that acc plus a full beat never overflows before clamping
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + $clog2(LANE_NUM) + 2;
    localparam logic signed [SUM_WIDTH-1:0] SMAX =
        SUM_WIDTH'({1'b0, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [SUM_WIDTH-1:0] SMIN = -SMAX - SUM_WIDTH'(1);
    localparam logic signed [SUM_WIDTH-1:0] UMAX = SUM_WIDTH'({ACC_WIDTH{1'b1}});

    logic signed [SUM_WIDTH-1:0] wide;

    always_comb begin
        wide = '0;
        sum  = '0;
        if (ALU_KIND == ALU_KIND_MUL) begin
            wide = SUM_WIDTH'($signed(acc_q));
            for (int unsigned k = 0; k < LANE_NUM; k++) begin
                wide = wide + SUM_WIDTH'($signed(s1_lane_q[k]));
            end
            if (wide > SMAX) begin
                sum = ACC_WIDTH'(SMAX);
            end else if (wide < SMIN) begin
                sum = ACC_WIDTH'(SMIN);
            end else begin
                sum = ACC_WIDTH'(wide);
            end
        end else begin
            wide = SUM_WIDTH'(acc_q);
            for (int unsigned k = 0; k < LANE_NUM; k++) begin
                wide = wide + SUM_WIDTH'(s1_lane_q[k]);
            end
            sum = (wide > UMAX) ? {ACC_WIDTH{1'b1}} : ACC_WIDTH'(wide);
        end
    end
`else
    always_comb begin
        sum = acc_q;
        for (int unsigned k = 0; k < LANE_NUM; k++) begin
            sum = sum + s1_lane_q[k];
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            beats_q <= '0;
        end else if (s1_valid_q) begin
            if (s1_last_q) begin
                res_q   <= sum;
                beats_q <= cnt_q + BEAT_CNT_WIDTH'(1);
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + BEAT_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StAcc;
        end else begin
            state_q <= state_d;
        end
    end

    // StWait covers the cycle the last beat spends in stage 2
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAcc: begin
                in_ready = 1'b1;
                if (bus.in_valid_i && bus.in_last_i) begin
                    state_d = StWait;
                end
            end
            StWait: state_d = StHold;
            StHold: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

endmodule

// File: tb/tb_alu_mac_array.sv
// Bench: four alu_mac_array variants (XNOR/32, MUL/32, MUL/16, zero-kind/32) share one
// stimulus stream; a vector-level model predicts handshakes and results for each.
module tb_alu_mac_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    alu_mac_array_if #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(32)) if0 ();
    alu_mac_array_if #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(32)) if1 ();
    alu_mac_array_if #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(16)) if2 ();
    alu_mac_array_if #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(32)) if3 ();

    assign if0.in_valid_i = in_valid;  assign if0.in_last_i = in_last;
    assign if0.a_i = a;  assign if0.b_i = b;  assign if0.out_ready_i = out_ready;
    assign if1.in_valid_i = in_valid;  assign if1.in_last_i = in_last;
    assign if1.a_i = a;  assign if1.b_i = b;  assign if1.out_ready_i = out_ready;
    assign if2.in_valid_i = in_valid;  assign if2.in_last_i = in_last;
    assign if2.a_i = a;  assign if2.b_i = b;  assign if2.out_ready_i = out_ready;
    assign if3.in_valid_i = in_valid;  assign if3.in_last_i = in_last;
    assign if3.a_i = a;  assign if3.b_i = b;  assign if3.out_ready_i = out_ready;

    alu_mac_array #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(32), .ALU_KIND(0)) u_d0 (
        .clk_i(clk), .rst_i(rst), .bus(if0.slave));
    alu_mac_array #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(32), .ALU_KIND(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .bus(if1.slave));
    alu_mac_array #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(16), .ALU_KIND(1)) u_d2 (
        .clk_i(clk), .rst_i(rst), .bus(if2.slave));
    alu_mac_array #(.DATA_WIDTH(8), .LANE_NUM(4), .ACC_WIDTH(32), .ALU_KIND(2)) u_d3 (
        .clk_i(clk), .rst_i(rst), .bus(if3.slave));

    logic        dut_ready [4];
    logic        dut_valid [4];
    logic [31:0] dut_acc   [4];
    logic [15:0] dut_beats [4];

    assign dut_ready[0] = if0.in_ready_o;  assign dut_valid[0] = if0.out_valid_o;
    assign dut_ready[1] = if1.in_ready_o;  assign dut_valid[1] = if1.out_valid_o;
    assign dut_ready[2] = if2.in_ready_o;  assign dut_valid[2] = if2.out_valid_o;
    assign dut_ready[3] = if3.in_ready_o;  assign dut_valid[3] = if3.out_valid_o;
    assign dut_acc[0] = if0.acc_o;  assign dut_acc[1] = if1.acc_o;
    assign dut_acc[2] = {16'h0, if2.acc_o};  assign dut_acc[3] = if3.acc_o;
    assign dut_beats[0] = if0.beats_o;  assign dut_beats[1] = if1.beats_o;
    assign dut_beats[2] = if2.beats_o;  assign dut_beats[3] = if3.beats_o;

    int kind_of [4] = '{0, 1, 1, 2};
    int w_of    [4] = '{32, 32, 16, 32};

`ifdef ALU_ACC_SAT_EN
    localparam logic [31:0] W16_EXP = 32'h0000_7FFF;
`else
    localparam logic [31:0] W16_EXP = 32'h0000_F40C;
`endif

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s dut%0d @%0t: got 0x%0h, expected 0x%0h", name, d, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Vector-level reference: sum of lane results per beat, accumulated per vector
    function automatic longint beat_val(input int kind, input logic [31:0] av,
                                        input logic [31:0] bv);
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = av[k*8 +: 8];
            y = bv[k*8 +: 8];
            if (kind == 0) s += longint'($countones(~(x ^ y)));
            else if (kind == 1) s += longint'($signed(x)) * longint'($signed(y));
        end
        return s;
    endfunction

    function automatic longint acc_add(input int d, input longint acc, input longint beat);
        longint s;
        longint lim;
        s   = acc + beat;
        lim = longint'(1) << w_of[d];
`ifdef ALU_ACC_SAT_EN
        if (kind_of[d] == 1) begin
            if (s > lim / 2 - 1) s = lim / 2 - 1;
            else if (s < -(lim / 2)) s = -(lim / 2);
        end else if (s > lim - 1) begin
            s = lim - 1;
        end
`endif
        return s & (lim - 1);
    endfunction

    bit          pend = 1'b0;
    int          cyc = 0;
    int          valid_at = 0;
    longint      part_acc [4];
    logic [15:0] part_cnt = '0;
    logic [31:0] res_acc  [4];
    logic [15:0] res_beats = '0;

    initial begin
        for (int d = 0; d < 4; d++) begin
            part_acc[d] = 0;
            res_acc[d]  = '0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                pend     = 1'b0;
                part_cnt = '0;
                for (int d = 0; d < 4; d++) part_acc[d] = 0;
            end else if (pend) begin
                if (cyc >= valid_at && out_ready) pend = 1'b0;
            end else if (in_valid) begin
                part_cnt = part_cnt + 16'd1;
                for (int d = 0; d < 4; d++) begin
                    part_acc[d] = acc_add(d, part_acc[d], beat_val(kind_of[d], a, b));
                end
                if (in_last) begin
                    for (int d = 0; d < 4; d++) begin
                        res_acc[d]  = 32'(part_acc[d]);
                        part_acc[d] = 0;
                    end
                    res_beats = part_cnt;
                    part_cnt  = '0;
                    pend      = 1'b1;
                    valid_at  = cyc + 2;
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 4; d++) begin
                    chk("in_ready", d, 32'(dut_ready[d]), 32'(!pend));
                    chk("out_valid", d, 32'(dut_valid[d]), 32'(pend && cyc >= valid_at));
                    if (pend && cyc >= valid_at) begin
                        chk("acc", d, dut_acc[d], res_acc[d]);
                        chk("beats", d, 32'(dut_beats[d]), 32'(res_beats));
                    end
                end
            end
        end
    end

    task automatic beat(input logic [31:0] av, input logic [31:0] bv, input bit last);
        a        = av;
        b        = bv;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for the result, pin it against a hand value, optionally stall, then take it
    task automatic finish_vec(input string name, input int d, input logic [31:0] e_acc,
                              input logic [15:0] e_beats, input int hold);
        int n = 0;
        while (!dut_valid[0] && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!dut_valid[0]) begin
            chk({name, "_timeout"}, 0, 32'(dut_valid[0]), 32'd1);
        end else begin
            chk({name, "_acc"}, d, dut_acc[d], e_acc);
            chk({name, "_beats"}, d, 32'(dut_beats[d]), 32'(e_beats));
        end
        repeat (hold) @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_acc", 0, dut_acc[0], 32'd0);
        chk("rst_beats", 0, 32'(dut_beats[0]), 32'd0);
        chk("rst_valid", 0, 32'(dut_valid[0]), 32'd0);
        chk("rst_ready", 0, 32'(dut_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // Single XNOR beat, then backpressure with in_valid pulses that must be ignored
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        a        = 32'h1234_5678;
        in_valid = 1'b1;
        in_last  = 1'b1;
        finish_vec("xnor1", 0, 32'd32, 16'd1, 5);
        in_last = 1'b0;

        // Three MUL beats with gaps
        beat(32'h0303_0303, 32'hFEFE_FEFE, 1'b0);
        idle(1);
        beat(32'h0303_0303, 32'hFEFE_FEFE, 1'b0);
        idle(2);
        beat(32'h0303_0303, 32'hFEFE_FEFE, 1'b1);
        finish_vec("mul3", 1, 32'hFFFF_FFB8, 16'd3, 0);

        // Narrow accumulator overflow
        beat(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0);
        beat(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b0);
        beat(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b1);
        finish_vec("w16", 2, W16_EXP, 16'd3, 0);

        // Reset after two beats: partial sum and the in-flight beat are dropped
        beat(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0);
        beat(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 0, 32'(dut_valid[0]), 32'd0);
        chk("midrst_acc", 0, dut_acc[0], 32'd0);
        @(posedge clk);
        #1;
        beat(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_vec("post_rst", 0, 32'd0, 16'd1, 0);

        // Zero-kind lanes
        beat(32'hA5C3_1E77, 32'h5A3C_E188, 1'b0);
        beat(32'h0123_4567, 32'h89AB_CDEF, 1'b1);
        finish_vec("kind2", 3, 32'd0, 16'd2, 0);

        // Mixed-sign lanes in one beat
        beat(32'h0102_03FF, 32'h04FD_8001, 1'b1);
        finish_vec("mulmix", 1, 32'hFFFF_FE7D, 16'd1, 0);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
